fsmc_req_arbiter: RTL

Two-port request arbiter and sequencer in front of the generic FSMC controller. It accepts single-beat FSMC read/write commands from two independent requesters, for example a CPU register port and a DMA engine, and grants them round-robin. Each granted command is driven onto the controller's AP CTRL start/idle/done interface with the timing profile of the granted port. A per-port completion response carries read data back.

---
 rtl/fsmc_req_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fsmc_req_arbiter.sv
// fsmc_req_arbiter
// Two-port round-robin request arbiter and sequencer placed in front of the
// generic FSMC controller. Each accepted single-beat command is replayed onto
// the controller's start/idle/done interface together with the timing profile
// of the port that issued it. A one-cycle response pulse returns to that port
// when the controller signals done; read data rides along with it.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   sN_cmd_valid/ready          command handshake of port N (N = 0, 1)
//   sN_cmd_addr/is_rd/wdata/mask  command fields of port N
//   sN_addr_set/data_set/data_hold  timing profile of port N (cycles - 1)
//   sN_resp_valid/rdata         completion pulse and read data of port N
//   ctrler_start/idle/done      controller start/idle/done handshake
//   addr_set/data_set/data_hold timing profile driven to the controller
//   wdata/data_mask/trans_addr/is_rd  transfer fields driven to the controller
//   rd_data/rd_valid            controller read-data stream

module fsmc_req_arbiter #(
    parameter real simulation_delay = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s0_cmd_valid,
    output logic        s0_cmd_ready,
    input  logic [25:0] s0_cmd_addr,
    input  logic        s0_cmd_is_rd,
    input  logic [15:0] s0_cmd_wdata,
    input  logic [1:0]  s0_cmd_mask,
    input  logic [7:0]  s0_addr_set,
    input  logic [7:0]  s0_data_set,
    input  logic [7:0]  s0_data_hold,
    output logic        s0_resp_valid,
    output logic [15:0] s0_resp_rdata,

    input  logic        s1_cmd_valid,
    output logic        s1_cmd_ready,
    input  logic [25:0] s1_cmd_addr,
    input  logic        s1_cmd_is_rd,
    input  logic [15:0] s1_cmd_wdata,
    input  logic [1:0]  s1_cmd_mask,
    input  logic [7:0]  s1_addr_set,
    input  logic [7:0]  s1_data_set,
    input  logic [7:0]  s1_data_hold,
    output logic        s1_resp_valid,
    output logic [15:0] s1_resp_rdata,

    output logic        ctrler_start,
    input  logic        ctrler_idle,
    input  logic        ctrler_done,
    output logic [7:0]  addr_set,
    output logic [7:0]  data_set,
    output logic [7:0]  data_hold,
    output logic [15:0] wdata,
    output logic [1:0]  data_mask,
    output logic [25:0] trans_addr,
    output logic        is_rd,
    input  logic [15:0] rd_data,
    input  logic        rd_valid
);

    // Registered updates carry no explicit delay in this synthesizable
    // implementation; the parameter is kept so existing instantiations that
    // override it still elaborate.
    if (simulation_delay < 0.0) begin : g_negative_delay_unused
    end

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state;
    logic        last_grant;   // port granted most recently
    logic        grant_port;   // port owning the transfer in flight
    logic        grant_sel;    // port that would win in the current cycle
    logic        handshake;
    logic [15:0] resp_data;

    // Round-robin choice: a lone requester wins outright, on a tie the port
    // that did not win last time goes first.
    always_comb begin
        // NOTE: default assigned first so every path drives grant_sel and no latch is inferred.
        grant_sel = 1'b0;
        if (s0_cmd_valid && s1_cmd_valid) begin
            grant_sel = ~last_grant;
        end else if (s1_cmd_valid) begin
            grant_sel = 1'b1;
        end
    end

    // Ready is a pure function of state and valid; gating with rst keeps it
    // low throughout reset even while a requester holds valid.
    assign handshake    = !rst && (state == IDLE) && (s0_cmd_valid || s1_cmd_valid);
    assign s0_cmd_ready = handshake && !grant_sel;
    assign s1_cmd_ready = handshake &&  grant_sel;

    assign ctrler_start  = (state == START);
    assign s0_resp_valid = (state == RESP) && !grant_port;
    assign s1_resp_valid = (state == RESP) &&  grant_port;
    assign s0_resp_rdata = resp_data;
    assign s1_resp_rdata = resp_data;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_port <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state      <= START;
                        last_grant <= grant_sel;
                        grant_port <= grant_sel;
                    end
                end
                // Start stays asserted until the controller reports idle on
                // the same edge; a stuck-busy controller simply stalls here.
                START:   if (ctrler_idle) state <= WAIT;
                WAIT:    if (ctrler_done) state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Transfer fields load only on the handshake edge, so they stay stable
    // for the complete controller transfer of the granted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_set   <= '0;
            data_set   <= '0;
            data_hold  <= '0;
            wdata      <= '0;
            data_mask  <= 2'b11;
            trans_addr <= '0;
            is_rd      <= 1'b0;
        end else if (handshake) begin
            if (grant_sel) begin
                addr_set   <= s1_addr_set;
                data_set   <= s1_data_set;
                data_hold  <= s1_data_hold;
                wdata      <= s1_cmd_wdata;
                data_mask  <= s1_cmd_mask;
                trans_addr <= s1_cmd_addr;
                is_rd      <= s1_cmd_is_rd;
            end else begin
                addr_set   <= s0_addr_set;
                data_set   <= s0_data_set;
                data_hold  <= s0_data_hold;
                wdata      <= s0_cmd_wdata;
                data_mask  <= s0_cmd_mask;
                trans_addr <= s0_cmd_addr;
                is_rd      <= s0_cmd_is_rd;
            end
        end
    end

    // Read data is captured only for read transfers; after a write the
    // response data keeps the last captured value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data <= '0;
        end else if ((state == WAIT) && rd_valid && is_rd) begin
            resp_data <= rd_data;
        end
    end

endmodule
